wb_regfile: RTL and testbench
=============================

# wb_regfile

General-purpose register file plus HI/LO pair for the five-stage MIPS core, written from the write-back stage and read by decode. It holds 32 GPRs with $0 hardwired to zero, two combinational read ports with same-cycle write-to-read bypass, and the HI/LO special registers used by multiply/divide and MTHI/MTLO. It sits at the consuming end of the MEM/WB pipeline register: WB-stage outputs drive its write ports directly, and the ID stage sees the value being written back in the same cycle.

## Interface

Parameters:
- DATA_W, 32, width of every GPR, HI and LO
- ADDR_W, 5, GPR address width; the file holds 2**ADDR_W entries

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  GPR write enable (from WB wreg)
- waddr  in  ADDR_W  GPR write address (from WB wd)
- wdata  in  DATA_W  GPR write data (from WB wdata)
- re1  in  1  read port 1 enable
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data, combinational
- re2  in  1  read port 2 enable
- raddr2  in  ADDR_W  read port 2 address
- rdata2  out  DATA_W  read port 2 data, combinational
- whilo  in  1  HI/LO write enable (from WB)
- hi_i  in  DATA_W  HI write data
- lo_i  in  DATA_W  LO write data
- hi_o  out  DATA_W  current HI, registered
- lo_o  out  DATA_W  current LO, registered

## Operation

- Storage: regs[1..31], HI, LO as flops. regs[0] is not stored; it always reads 0.
- Reset: on a rising edge with rst=1, all regs[1..31], HI and LO clear to 0. Writes presented in that cycle are dropped.
- GPR write: on a rising edge with rst=0, we=1 and waddr!=0, regs[waddr] <= wdata. A write to address 0 is discarded without error.
- HI/LO write: on a rising edge with rst=0 and whilo=1, HI <= hi_i and LO <= lo_i; both are always written together.
- GPR and HI/LO writes are independent and may occur in the same cycle.
- Each read port n (1, 2) resolves in this priority order:
  1. rst=1: 0
  2. raddrn=0: 0
  3. ren=0: 0
  4. we=1 and waddr==raddrn (bypass): wdata
  5. otherwise: regs[raddrn]
- Ports 1 and 2 are fully independent. Both may address the same register, and both may bypass in the same cycle.
- HI/LO are not bypassed. hi_o/lo_o show the registered values only. EX-stage forwarding from MEM and WB covers HI/LO hazards.

## Timing

- Write latency: data presented in cycle N is in storage after edge N+1. It is visible on the same-cycle read path in cycle N through bypass, and on the normal path from cycle N+1.
- Read latency: zero cycles, purely combinational from raddr/re/we/waddr/wdata/rst.
- hi_o/lo_o change only on a clock edge, one cycle after whilo. They reset to 0 on the first rising edge with rst=1.
- rdata1/rdata2 are 0 combinationally while rst=1.
- Reset during an active write: the write is lost and the register reads 0 afterwards.
- No stall input. The upstream MEM/WB register holds we low or stable as required, and a stable repeated write is idempotent.

## Test plan

- Reset clear: write 0xDEADBEEF to r5 and HI=0x1, LO=0x2, then assert rst for one edge. Required: r5 reads 0, hi_o=0, lo_o=0, and rdata1=rdata2=0 during rst.
- Write then read: we=1, waddr=7, wdata=0x12345678 for one cycle; next cycle read raddr1=7, re1=1. Required: rdata1=0x12345678. With re1=0, rdata1=0.
- Bypass: in the same cycle drive we=1, waddr=9, wdata=0xA5A5A5A5 with raddr1=raddr2=9 and re1=re2=1, where r9 previously held 0x11. Required: both ports read 0xA5A5A5A5 that cycle, and 0xA5A5A5A5 from storage the next cycle.
- $zero: we=1, waddr=0, wdata=0xFFFFFFFF with raddr1=0, re1=1, in the same cycle and the next. Required: rdata1=0 in both cycles.
- HI/LO: whilo=1, hi_i=0xCAFE0000, lo_i=0x0000BEEF. Required: hi_o/lo_o keep their old values that cycle and read 0xCAFE0000/0x0000BEEF after the edge. A simultaneous GPR write to r3 also commits.
- Sweep: write r1..r31 with the value (index*0x01010101) on consecutive cycles, then read all entries on both ports with random re. Required: exact match when re=1, 0 when re=0, and r0=0.

Source files
------------

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//
// GPR file plus HI/LO pair for the five-stage MIPS core. The write-back stage
// writes it and the decode stage reads it. It holds 31 stored GPRs, and $0 is
// hardwired to zero. It has two combinational read ports with a same-cycle
// write-to-read bypass, and registered HI/LO special registers.
//
// Ports:
//   clk     in   clock, all state updates on the rising edge
//   rst     in   synchronous active-high reset; clears GPRs, HI and LO
//   we      in   GPR write enable (WB wreg)
//   waddr   in   GPR write address (WB wd)
//   wdata   in   GPR write data (WB wdata)
//   re1     in   read port 1 enable
//   raddr1  in   read port 1 address
//   rdata1  out  read port 1 data, combinational
//   re2     in   read port 2 enable
//   raddr2  in   read port 2 address
//   rdata2  out  read port 2 data, combinational
//   whilo   in   HI/LO write enable (both written together)
//   hi_i    in   HI write data
//   lo_i    in   LO write data
//   hi_o    out  current HI, registered (not bypassed)
//   lo_o    out  current LO, registered (not bypassed)
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    // Entry 0 is deliberately absent: $0 is never stored.
    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic [DATA_W-1:0] store1;
    logic [DATA_W-1:0] store2;

    // GPR storage. The address is decoded per entry, so a write to $0 matches
    // nothing and is dropped without indexing outside the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    regs_q[i] <= wdata;
                end
            end
        end
    end

    // HI/LO storage, independent of GPR writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (whilo) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    // Stored-value read muxes. No entry matches address 0, so the mux yields
    // 0 there.
    always_comb begin
        store1 = '0;
        store2 = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (raddr1 == ADDR_W'(i)) begin
                store1 = regs_q[i];
            end
            if (raddr2 == ADDR_W'(i)) begin
                store2 = regs_q[i];
            end
        end
    end

    // Read port resolution in priority order: reset, $0, disabled, bypass,
    // storage.
    always_comb begin
        if (rst) begin
            rdata1 = '0;
        end else if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (!re1) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = store1;
        end
    end

    always_comb begin
        if (rst) begin
            rdata2 = '0;
        end else if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (!re2) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = store2;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks   = 0;
    int failures = 0;

    wb_regfile #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re1   (re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .re2   (re2),
        .raddr2(raddr2),
        .rdata2(rdata2),
        .whilo (whilo),
        .hi_i  (hi_i),
        .lo_i  (lo_i),
        .hi_o  (hi_o),
        .lo_o  (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Load r5 and HI/LO, then confirm they hold data.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        whilo = 1'b1; hi_i = 32'h1; lo_i = 32'h2;
        tick();
        we = 1'b0; whilo = 1'b0;
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        checks++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2) begin
            failures++;
            $display("FAIL reset_preload_hilo: hi=%h lo=%h want 00000001/00000002", hi_o, lo_o);
        end
        checks++;
        if (rdata1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL reset_preload_r5: got %h want deadbeef", rdata1);
        end
        // Assert reset with a write active; reads must be 0 during reset.
        rst = 1'b1;
        re2 = 1'b1; raddr2 = 5'd5;
        we = 1'b1; waddr = 5'd5; wdata = 32'h55555555;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_reads_zero: rd1=%h rd2=%h want 0", rdata1, rdata2);
        end
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_r5_cleared: rd1=%h rd2=%h want 0", rdata1, rdata2);
        end
        checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_hilo_cleared: hi=%h lo=%h want 0", hi_o, lo_o);
        end
        re1 = 1'b0; re2 = 1'b0;
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        tick();
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd7;
        #1;
        checks++;
        if (rdata1 !== 32'h12345678) begin
            failures++;
            $display("FAIL write_read: got %h want 12345678", rdata1);
        end
        re1 = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            failures++;
            $display("FAIL write_read_re0: got %h want 0", rdata1);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd9; wdata = 32'h11;
        tick();
        re1 = 1'b1; raddr1 = 5'd9;
        re2 = 1'b1; raddr2 = 5'd9;
        #1;
        checks++;
        if (rdata1 !== 32'h11 || rdata2 !== 32'h11) begin
            failures++;
            $display("FAIL bypass_preload: rd1=%h rd2=%h want 00000011", rdata1, rdata2);
        end
        wdata = 32'hA5A5A5A5;
        #1;
        checks++;
        if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL bypass_same_cycle: rd1=%h rd2=%h want a5a5a5a5", rdata1, rdata2);
        end
        // A disabled port must not bypass.
        re2 = 1'b0;
        #1;
        checks++;
        if (rdata2 !== 32'h0 || rdata1 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL bypass_re0: rd1=%h rd2=%h want a5a5a5a5/0", rdata1, rdata2);
        end
        re2 = 1'b1;
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL bypass_stored: rd1=%h rd2=%h want a5a5a5a5", rdata1, rdata2);
        end
        re1 = 1'b0; re2 = 1'b0;
    endtask

    task automatic test_zero();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        re1 = 1'b1; raddr1 = 5'd0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            failures++;
            $display("FAIL zero_same_cycle: got %h want 0", rdata1);
        end
        tick();
        checks++;
        if (rdata1 !== 32'h0) begin
            failures++;
            $display("FAIL zero_next_cycle: got %h want 0", rdata1);
        end
        we = 1'b0; re1 = 1'b0;
    endtask

    task automatic test_hilo();
        whilo = 1'b1; hi_i = 32'hCAFE0000; lo_i = 32'h0000BEEF;
        we = 1'b1; waddr = 5'd3; wdata = 32'h33333333;
        #1;
        checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
            failures++;
            $display("FAIL hilo_no_bypass: hi=%h lo=%h want 0/0", hi_o, lo_o);
        end
        tick();
        whilo = 1'b0; we = 1'b0;
        hi_i = 32'h0BAD0BAD; lo_i = 32'h0BAD0BAD;
        re1 = 1'b1; raddr1 = 5'd3;
        #1;
        checks++;
        if (hi_o !== 32'hCAFE0000 || lo_o !== 32'h0000BEEF) begin
            failures++;
            $display("FAIL hilo_written: hi=%h lo=%h want cafe0000/0000beef", hi_o, lo_o);
        end
        checks++;
        if (rdata1 !== 32'h33333333) begin
            failures++;
            $display("FAIL hilo_gpr_concurrent: got %h want 33333333", rdata1);
        end
        tick();
        checks++;
        if (hi_o !== 32'hCAFE0000 || lo_o !== 32'h0000BEEF) begin
            failures++;
            $display("FAIL hilo_hold: hi=%h lo=%h want cafe0000/0000beef", hi_o, lo_o);
        end
        re1 = 1'b0;
    endtask

    task automatic test_sweep();
        logic [31:0] exp1;
        logic [31:0] exp2;
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h01010101;
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            re1 = 1'($urandom_range(0, 1));
            re2 = 1'($urandom_range(0, 1));
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            exp1 = re1 ? 32'(i) * 32'h01010101 : 32'h0;
            exp2 = re2 ? 32'(31 - i) * 32'h01010101 : 32'h0;
            checks++;
            if (rdata1 !== exp1) begin
                failures++;
                $display("FAIL sweep_p1 r%0d re=%0d: got %h want %h", i, re1, rdata1, exp1);
            end
            checks++;
            if (rdata2 !== exp2) begin
                failures++;
                $display("FAIL sweep_p2 r%0d re=%0d: got %h want %h", 31 - i, re2, rdata2, exp2);
            end
        end
        re1 = 1'b0; re2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        whilo = 1'b0; hi_i = '0; lo_i = '0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero();
        test_hilo();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
